rv_fetch: RTL

Instruction fetch stage directly upstream of `rv_decode_instr`. Holds the program counter, issues word requests to instruction memory over a request/grant/response handshake, and buffers returned words with their PCs. Presents them to decode via a valid/ready interface, and supports a single-cycle redirect (branch/jump/trap) that flushes all in-flight and buffered instructions.

---
 rtl/rv_pkg.sv | 40 ++++
 rtl/rv_fetch_fifo.sv | 61 ++++++
 rtl/rv_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 front-end package.
// Holds machine-width constants, the default reset PC, the major opcodes used by
// decode, the fetch FIFO payload type and the fetch-stage state encoding.
package rv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Major opcodes (instr[6:0]) shared with rv_decode_instr.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    StReset,
    StRun
  } fetch_state_e;

  // Clear the byte offset of an address.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Two-entry synchronous FIFO of {pc, instr} for the fetch stage.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   flush_i        drop all entries (dominates push/pop)
//   push_i, data_i write one entry
//   pop_i          consume the head entry
//   valid_o        head entry valid
//   head_o         registered head entry
//   count_o        occupancy 0..2
// Push and pop may coincide at any occupancy, including full.
module rv_fetch_fifo
  import rv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t mem_q [2];
  logic [1:0]   count_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop_i & (count_q != 2'd0);
  assign do_push = push_i & ((count_q != 2'd2) | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else if (do_push && do_pop) begin
      // Entry 0 is always the head; a full FIFO shifts and refills the tail.
      if (count_q == 2'd1) begin
        mem_q[0] <= data_i;
      end else begin
        mem_q[0] <= mem_q[1];
        mem_q[1] <= data_i;
      end
    end else if (do_pop) begin
      mem_q[0] <= mem_q[1];
      count_q  <= count_q - 2'd1;
    end else if (do_push) begin
      mem_q[count_q[0]] <= data_i;
      count_q           <= count_q + 2'd1;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = mem_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch stage feeding rv_decode_instr.
// Holds the PC, issues word fetches over req/gnt/rvalid, buffers returned words
// with their PCs and hands them to decode over valid/ready. A redirect reloads
// the PC and flushes everything buffered or still in flight.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   redirect_i, redirect_pc_i    branch/jump/trap target (bits [1:0] ignored)
//   imem_req_o, imem_addr_o      fetch request and word address
//   imem_gnt_i                   request accepted
//   imem_rvalid_i, imem_rdata_i  in-order response
//   instr_valid_o, instr_o, pc_o instruction to decode
//   instr_ready_i                decode accepts
module rv_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [1:0]      outstanding_q, outstanding_d;
  logic [1:0]      discard_q, discard_d;
  logic [XLEN-1:0] inflight_pc_q [2];

  logic         grant;
  logic         resp;
  logic         credit_ok;
  logic         inflight_wr_idx;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_valid;
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t fifo_data;

  // Every granted word must have a FIFO slot when it returns. A slot being
  // drained by decode this cycle already counts as free, which is what lets a
  // 1-cycle memory sustain one instruction per cycle.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count})
                     < (3'd2 + {2'b00, fifo_valid & instr_ready_i});

  assign imem_req_o  = (state_q == StRun) & credit_ok;
  assign imem_addr_o = fetch_pc_q;

  assign grant = imem_req_o & imem_gnt_i;
  // Responses with nothing in flight (e.g. for pre-reset grants) are ignored.
  assign resp  = imem_rvalid_i & (outstanding_q != 2'd0);

  // A flushed head is not delivered, even if decode was ready.
  assign fifo_pop  = fifo_valid & instr_ready_i & ~redirect_i;
  assign fifo_push = resp & (discard_q == 2'd0) & ~redirect_i;
  assign fifo_data = '{pc: inflight_pc_q[0], instr: imem_rdata_i};

  // Credit limits outstanding to at most 1 whenever a grant happens, so the
  // new PC lands in slot 0 or 1 depending on whether slot 0 drains now.
  assign inflight_wr_idx = outstanding_q[0] & ~resp;

  always_comb begin
    outstanding_d = outstanding_q;
    if (grant && !resp) begin
      outstanding_d = outstanding_q + 2'd1;
    end else if (!grant && resp) begin
      outstanding_d = outstanding_q - 2'd1;
    end

    discard_d = discard_q;
    if (redirect_i) begin
      // Everything still in flight after this edge is stale, including a word
      // granted this cycle.
      discard_d = outstanding_d;
    end else if (resp && (discard_q != 2'd0)) begin
      discard_d = discard_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= StReset;
      fetch_pc_q       <= RESET_PC;
      outstanding_q    <= 2'd0;
      discard_q        <= 2'd0;
      inflight_pc_q[0] <= '0;
      inflight_pc_q[1] <= '0;
    end else begin
      state_q       <= StRun;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;

      if (redirect_i) begin
        fetch_pc_q <= align_word(redirect_pc_i);
      end else if (grant) begin
        fetch_pc_q <= fetch_pc_q + XLEN'(INSTR_BYTES);
      end

      if (resp) begin
        inflight_pc_q[0] <= inflight_pc_q[1];
      end
      if (grant) begin
        inflight_pc_q[inflight_wr_idx] <= fetch_pc_q;
      end
    end
  end

  rv_fetch_fifo u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (fifo_push),
    .data_i  (fifo_data),
    .pop_i   (fifo_pop),
    .valid_o (fifo_valid),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign instr_valid_o = fifo_valid;
  assign instr_o       = fifo_head.instr;
  assign pc_o          = fifo_head.pc;

endmodule
